serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder. Computes a + b + cin for WIDTH-bit operands, one bit per clock, LSB first.
- Uses a single full-adder cell and a carry flip-flop.
- Addition counterpart of the half/full subtractor cells. Used in area-constrained arithmetic paths where latency is acceptable.
- Start/done handshake to the controlling block.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  augend; captured on accepted start
- b  input  WIDTH  addend; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  registered result; held until next completion
- cout  output  1  registered carry-out; held with sum

Behaviour:
- Clocking: all state changes on the rising edge of clk. rst is synchronous and active-high, and has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flip-flop and bit counter are cleared to 0.
- State machine:
  - IDLE: busy=0, done=0.
    - start=1 → load a, b into shift registers, cin into the carry flip-flop, and counter=0; go to SHIFT.
    - start=0 → stay.
  - SHIFT: busy=1. Each cycle:
    - s = a_sh[0]^b_sh[0]^c.
    - c ← majority(a_sh[0], b_sh[0], c).
    - s shifts into the result register from the MSB end; a_sh and b_sh shift right.
    - counter increments.
    - When counter reaches WIDTH-1 on this edge → copy the completed result to sum, the final carry to cout; go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle; go to IDLE unconditionally.
- Latency:
  - start accepted at edge E → done=1 during the cycle after edge E+WIDTH.
  - Total: WIDTH+1 cycles from accept to done. Next start is accepted in the cycle after done.
- start while busy (SHIFT or DONE): ignored; no queuing; a/b/cin changes have no effect on the operation in flight.
- sum/cout update only on the SHIFT→DONE transition. Partial results are never visible on the outputs.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = a+b+cin exactly (WIDTH+1-bit result).
- Reset mid-operation: abort immediately, return to IDLE with all reset values, including sum=0 and cout=0. No done pulse is produced for the aborted operation.
- start held high continuously: each operation completes, then restarts in the first IDLE cycle, giving back-to-back results every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), reset 0, registered and updated together with sum.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - The carry into the MSB is captured during the final SHIFT cycle.
- When undefined:
  - No ovf port and no additional logic.
  - Port list and all other behaviour are identical.

Test Plan:
- Reset: assert rst 2 cycles with start=1 → busy=0, done=0, sum=0x00, cout=0 throughout; first accept occurs only after rst deasserts.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → done exactly 9 cycles after accept; sum=0x96, cout=0, busy low the following cycle.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Busy-start: accept a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 at cycle 3 of SHIFT → result sum=0x30, cout=0; no second done pulse.
- Reset mid-op: accept a=0x80, b=0x80; assert rst after 4 SHIFT cycles → next cycle busy=0, sum=0, cout=0; no done pulse. Subsequent 0x01+0x02 → sum=0x03.
- SERIAL_ADD_OVF_EN defined:
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 → sum=0x00, cout=1, ovf=1.
  - 0xFF+0x01 → ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock LSB first; optional ovf via SERIAL_ADD_OVF_EN.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; results held until the next completion.
// Backpressure: none; start is only sampled in IDLE and ignored while busy (no queuing).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             c_nxt;
  logic             last;

  // Single full-adder cell working on the low bits of the shift registers.
  assign s     = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
      c    <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_nxt;
          res  <= {s, res[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // Outputs only change here, so partial sums never leak out.
          if (last) begin
            sum  <= {s, res[WIDTH-1:1]};
            cout <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= c ^ c_nxt;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus hand sequences for multi-cycle cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[9];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_sum", 64'(sum), 64'(mon_e.s));
        chk("sb_cout", 64'(cout), 64'(mon_e.co));
`ifdef SERIAL_ADD_OVF_EN
        chk("sb_ovf", 64'(ovf), 64'(mon_e.ov));
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input int inj, input string nm);
    int k;
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    sb.push_back('{es, ec, eo});
    @(negedge clk);
    k = 1;
    chk({nm, "_accept_busy"}, 64'(busy), 64'd1);
    start = 1'b0;
    while (done !== 1'b1 && k < W + 6) begin
      if (k == inj) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
      end else if (k == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(k), 64'(W + 1));
    @(negedge clk);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int k2;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tbl[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;
    cin   = 1'b0;

    // Reset with start held high: nothing may be accepted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    end
    rst = 1'b0;
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, "rst_release");

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].s, tbl[i].co, tbl[i].ov, 0,
            $sformatf("vec%0d", i));
    end

    // start pulsed mid-operation with different operands must be ignored.
    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3, "busy_start");
    repeat (W + 4) @(negedge clk);
    chk("busy_start_no_restart", 64'(busy), 64'd0);

    // Reset after four shift cycles aborts without a done pulse.
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_busy", 64'(busy), 64'd1);
    chk("midop_sum_held", 64'(sum), 64'h30);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_busy", 64'(busy), 64'd0);
    chk("midop_rst_done", 64'(done), 64'd0);
    chk("midop_rst_sum", 64'(sum), 64'd0);
    chk("midop_rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("midop_idle", 64'(busy), 64'd0);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, "after_abort");

    // start held high: back-to-back results every W+2 cycles.
    sb.push_back('{8'h02, 1'b0, 1'b0});
    sb.push_back('{8'h02, 1'b0, 1'b0});
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 40);
    chk("b2b_first_latency", 64'(k), 64'(W + 1));
    k2 = 0;
    do begin
      @(negedge clk);
      k2++;
    end while (done !== 1'b1 && k2 < 40);
    chk("b2b_interval", 64'(k2), 64'(W + 2));
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("b2b_stop_busy", 64'(busy), 64'd0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
